// File: rtl/det2_loader.sv
// Serial-to-parallel loader feeding det2: collects a,b,c,d words over a
// valid/ready stream, checks in_last framing and holds each matrix until acked.
module det2_loader #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    input  logic          clr,
    output logic [DW-1:0] mat_a,
    output logic [DW-1:0] mat_b,
    output logic [DW-1:0] mat_c,
    output logic [DW-1:0] mat_d,
    output logic          out_valid,
    input  logic          out_ack,
    output logic          frame_err
);

    typedef enum logic {
        LOAD,
        HOLD
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [1:0]    idx;
    logic [1:0]    idx_next;
    logic [DW-1:0] stage_a;
    logic [DW-1:0] stage_b;
    logic [DW-1:0] stage_c;
    logic          accept;
    logic          commit;
    logic          stage_wr;
    logic          err_set;

    assign accept    = in_valid && in_ready;
    assign out_valid = (state == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // clr outranks a beat in LOAD; a malformed frame only rewinds idx so the
    // stale staging words are overwritten before the next commit
    always_comb begin
        state_next = state;
        idx_next   = idx;
        commit     = 1'b0;
        stage_wr   = 1'b0;
        err_set    = 1'b0;
        case (state)
            LOAD: begin
                if (clr) begin
                    idx_next = 2'd0;
                end else if (accept) begin
                    if (in_last && (idx == 2'd3)) begin
                        commit     = 1'b1;
                        idx_next   = 2'd0;
                        state_next = HOLD;
                    end else if (in_last || (idx == 2'd3)) begin
                        err_set  = 1'b1;
                        idx_next = 2'd0;
                    end else begin
                        stage_wr = 1'b1;
                        idx_next = idx + 2'd1;
                    end
                end
            end
            HOLD: begin
                if (out_ack) begin
                    state_next = LOAD;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= 2'd0;
            in_ready  <= 1'b0;
            stage_a   <= '0;
            stage_b   <= '0;
            stage_c   <= '0;
            mat_a     <= '0;
            mat_b     <= '0;
            mat_c     <= '0;
            mat_d     <= '0;
            frame_err <= 1'b0;
        end else begin
            idx      <= idx_next;
            in_ready <= (state_next == LOAD);
            if (stage_wr) begin
                case (idx)
                    2'd0:    stage_a <= in_data;
                    2'd1:    stage_b <= in_data;
                    2'd2:    stage_c <= in_data;
                    default: ;
                endcase
            end
            // all four outputs switch on the same edge so det2 never sees a mix
            if (commit) begin
                mat_a <= stage_a;
                mat_b <= stage_b;
                mat_c <= stage_c;
                mat_d <= in_data;
            end
            if (err_set) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule
